// File: rtl/promip_pkg.sv
// Shared field layout, register map and FSM encoding for the PROMIP measurement block.
// No logic: constants and types only.
// No flow control: compile-time definitions.
package promip_pkg;

    localparam int SEL_LSB     = 0;
    localparam int SEL_MSB     = 3;
    localparam int SEL_W       = SEL_MSB - SEL_LSB + 1;
    localparam int START_BIT   = 8;
    localparam int ABORT_BIT   = 9;
    localparam int RUN_BIT     = 10;
    localparam int ABORTED_BIT = 11;
    localparam int SEL_ERR_BIT = 12;
    localparam int SAT_BIT     = 13;

    localparam logic [7:0] ADDR_SENSOR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_REF_COUNTER   = 8'h04;
    localparam logic [7:0] ADDR_SENSOR_STATUS = 8'h08;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        COUNT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } meas_state_e;

    typedef struct packed {
        logic sat;
        logic sel_err;
        logic aborted;
    } sticky_t;

endpackage

// File: rtl/promip_osc_edge_sync.sv
// Synchronises the muxed oscillator into pclk and flags its rising edges.
// Latency: SYNC_STAGES pclk cycles from input transition to rise pulse.
// No backpressure: free-running, one pulse per detected edge.
module promip_osc_edge_sync
    import promip_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic osc,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
        end
    end

    // Older stage low, newer stage high.
    assign rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/promip_meas_ctrl.sv
// Register bank plus timed edge-count measurement of one selected ring oscillator.
// Latency: START at T -> ARM at T+1, result with dataready at T+ref_counter+SYNC_STAGES+2.
// No backpressure: writes are single-cycle strobes; ctrl writes are only honoured where legal.
module promip_meas_ctrl
    import promip_pkg::*;
#(
    parameter int NUM_SENSORS        = 8,
    parameter int SENSOR_CTRL_LENGTH = 16,
    parameter int REF_COUNTER_LENGTH = 32,
    parameter int SENSOR_STAT_LENGTH = 32,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          write,
    input  logic                          sensor_ctrl_select,
    input  logic                          ref_counter_select,
    input  logic                          sensor_status_select,
    input  logic [SENSOR_CTRL_LENGTH-1:0] sensor_ctrl_write_data,
    input  logic [REF_COUNTER_LENGTH-1:0] ref_counter_write_data,
    input  logic [NUM_SENSORS-1:0]        sens_osc,
    output logic [SENSOR_CTRL_LENGTH-1:0] sensor_ctrl,
    output logic [REF_COUNTER_LENGTH-1:0] ref_counter,
    output logic [SENSOR_STAT_LENGTH-1:0] sensor_status,
    output logic                          dataready,
    output logic [NUM_SENSORS-1:0]        sensor_en
);

    localparam int DRAIN_W = $clog2(SYNC_STAGES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SYNC_STAGES - 1);
    localparam logic [SEL_W:0]     NUM_SENS_L = NUM_SENSORS[SEL_W:0];
    localparam logic [REF_COUNTER_LENGTH-1:0] WIN_ONE = REF_COUNTER_LENGTH'(1);

    meas_state_e                   state_q, state_d;
    logic [SEL_W-1:0]              sel_q;
    logic [REF_COUNTER_LENGTH-1:0] ref_q, win_q;
    logic [SENSOR_STAT_LENGTH-1:0] edge_cnt_q, edge_cnt_d, status_q;
    logic [DRAIN_W-1:0]            drain_cnt_q;
    sticky_t                       sticky_q;

    logic             run, count_en, idle_like;
    logic             osc_mux, rise;
    logic             ctrl_wr, ref_wr, stat_rd;
    logic             wr_start, wr_abort, wr_sel_ok;
    logic [SEL_W-1:0] wr_sel;
    logic             set_aborted, set_sel_err, set_sat;
    logic             ctrl_wdata_unused;

    assign ctrl_wr   = write & sensor_ctrl_select;
    assign ref_wr    = write & ref_counter_select;
    assign stat_rd   = sensor_status_select & ~write;
    assign wr_sel    = sensor_ctrl_write_data[SEL_MSB:SEL_LSB];
    assign wr_abort  = ctrl_wr & sensor_ctrl_write_data[ABORT_BIT];
    assign wr_start  = ctrl_wr & sensor_ctrl_write_data[START_BIT] & ~sensor_ctrl_write_data[ABORT_BIT];
    assign wr_sel_ok = ({1'b0, wr_sel} < NUM_SENS_L);

    assign ctrl_wdata_unused = ^{sensor_ctrl_write_data[SENSOR_CTRL_LENGTH-1:ABORT_BIT+1],
                                 sensor_ctrl_write_data[START_BIT-1:SEL_MSB+1]};

    // DONE behaves like IDLE for register writes so a back-to-back START is not lost.
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign count_en  = (state_q == COUNT) || (state_q == DRAIN);

    // Oscillator mux ahead of the synchroniser; out-of-range SEL selects a constant 0.
    always_comb begin
        osc_mux = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sel_q == SEL_W'(i)) osc_mux = sens_osc[i];
        end
    end

    promip_osc_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .pclk   (pclk),
        .presetn(presetn),
        .osc    (osc_mux),
        .rise   (rise)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run       = 1'b0;
        dataready = 1'b1;
        case (state_q)
            IDLE, DONE: begin
                state_d = (wr_start && wr_sel_ok) ? ARM : IDLE;
            end
            ARM: begin
                run       = 1'b1;
                dataready = 1'b0;
                if (wr_abort)              state_d = IDLE;
                else if (ref_q == '0)      state_d = DRAIN;
                else                       state_d = COUNT;
            end
            COUNT: begin
                run       = 1'b1;
                dataready = 1'b0;
                if (wr_abort)              state_d = IDLE;
                else if (win_q == WIN_ONE) state_d = DRAIN;
            end
            DRAIN: begin
                dataready = 1'b0;
                if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (state_q == ARM) begin
            edge_cnt_d = '0;
        end else if (count_en && rise && (edge_cnt_q != '1)) begin
            edge_cnt_d = edge_cnt_q + SENSOR_STAT_LENGTH'(1);
        end
    end

    assign set_aborted = run && wr_abort;
    assign set_sel_err = idle_like && wr_start && !wr_sel_ok;
    assign set_sat     = count_en && rise && (edge_cnt_q == '1);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sel_q       <= '0;
            ref_q       <= '0;
            win_q       <= '0;
            edge_cnt_q  <= '0;
            drain_cnt_q <= '0;
            status_q    <= '0;
            sticky_q    <= '0;
        end else begin
            if (ref_wr) ref_q <= ref_counter_write_data;
            if (idle_like && ctrl_wr) sel_q <= wr_sel;

            if (state_q == ARM)        win_q <= ref_q;
            else if (state_q == COUNT) win_q <= win_q - WIN_ONE;

            edge_cnt_q  <= edge_cnt_d;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;

            // Result lands together with the dataready rise (DONE or abort-to-IDLE).
            if (set_aborted || (state_q == DRAIN && state_d == DONE)) begin
                status_q <= edge_cnt_d;
            end

            sticky_q.aborted <= set_aborted | (sticky_q.aborted & ~stat_rd);
            sticky_q.sel_err <= set_sel_err | (sticky_q.sel_err & ~stat_rd);
            sticky_q.sat     <= set_sat     | (sticky_q.sat     & ~stat_rd);
        end
    end

    always_comb begin
        sensor_en = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            sensor_en[i] = run && (sel_q == SEL_W'(i));
        end
    end

    always_comb begin
        sensor_ctrl                  = '0;
        sensor_ctrl[SEL_MSB:SEL_LSB] = sel_q;
        sensor_ctrl[RUN_BIT]         = run;
        sensor_ctrl[ABORTED_BIT]     = sticky_q.aborted;
        sensor_ctrl[SEL_ERR_BIT]     = sticky_q.sel_err;
        sensor_ctrl[SAT_BIT]         = sticky_q.sat;
    end

    assign ref_counter   = ref_q;
    assign sensor_status = status_q;

endmodule

// File: tb/tb_promip_meas_ctrl.sv
// Scoreboard bench for promip_meas_ctrl: stimulus pushes expected results, monitors pop on dataready rise.
module tb_promip_meas_ctrl;

    typedef struct {
        int     cyc;
        longint lo;
        longint hi;
        logic   aborted;
        logic   sat;
    } exp_t;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q1[$];
    exp_t        q2[$];

    logic        write1 = 0, csel1 = 0, rsel1 = 0, ssel1 = 0;
    logic [15:0] cdat1 = '0;
    logic [31:0] rdat1 = '0;
    logic [15:0] ctrl1;
    logic [31:0] ref1, stat1;
    logic        dr1;
    logic [7:0]  en1, osc1;

    logic        write2 = 0, csel2 = 0, rsel2 = 0, ssel2 = 0;
    logic [15:0] cdat2 = '0;
    logic [31:0] rdat2 = '0;
    logic [15:0] ctrl2;
    logic [31:0] ref2;
    logic [3:0]  stat2;
    logic        dr2;
    logic [7:0]  en2, osc2;

    logic        osc_a = 1'b0, osc_b = 1'b0;
    assign osc1 = {5'b0, osc_a, 2'b00};
    assign osc2 = {7'b0, osc_b};

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;
    initial begin #3;  forever #50 osc_a = ~osc_a; end  // 10 pclk period
    initial begin #2;  forever #20 osc_b = ~osc_b; end  // 4 pclk period

    promip_meas_ctrl u_dut (
        .pclk(pclk), .presetn(presetn), .write(write1),
        .sensor_ctrl_select(csel1), .ref_counter_select(rsel1), .sensor_status_select(ssel1),
        .sensor_ctrl_write_data(cdat1), .ref_counter_write_data(rdat1), .sens_osc(osc1),
        .sensor_ctrl(ctrl1), .ref_counter(ref1), .sensor_status(stat1),
        .dataready(dr1), .sensor_en(en1)
    );

    promip_meas_ctrl #(.SENSOR_STAT_LENGTH(4)) u_dut_sat (
        .pclk(pclk), .presetn(presetn), .write(write2),
        .sensor_ctrl_select(csel2), .ref_counter_select(rsel2), .sensor_status_select(ssel2),
        .sensor_ctrl_write_data(cdat2), .ref_counter_write_data(rdat2), .sens_osc(osc2),
        .sensor_ctrl(ctrl2), .ref_counter(ref2), .sensor_status(stat2),
        .dataready(dr2), .sensor_en(en2)
    );

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic ctrl_wr(input int u, input logic [15:0] d);
        if (u == 0) begin write1 = 1; csel1 = 1; cdat1 = d; end
        else        begin write2 = 1; csel2 = 1; cdat2 = d; end
        tick();
        write1 = 0; csel1 = 0; write2 = 0; csel2 = 0;
    endtask

    task automatic ref_wr(input int u, input logic [31:0] d);
        if (u == 0) begin write1 = 1; rsel1 = 1; rdat1 = d; end
        else        begin write2 = 1; rsel2 = 1; rdat2 = d; end
        tick();
        write1 = 0; rsel1 = 0; write2 = 0; rsel2 = 0;
    endtask

    task automatic stat_read(input int u);
        if (u == 0) ssel1 = 1; else ssel2 = 1;
        tick();
        ssel1 = 0; ssel2 = 0;
    endtask

    task automatic expect_done(input int u, input int c, input longint lo, input longint hi,
                               input logic ab, input logic sat);
        exp_t e;
        e.cyc = c; e.lo = lo; e.hi = hi; e.aborted = ab; e.sat = sat;
        if (u == 0) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic wait_drained(input int u, input int budget);
        int n = 0;
        while (((u == 0) ? q1.size() : q2.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        if (((u == 0) ? q1.size() : q2.size()) != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_u%0d: no dataready after %0d cycles, pending=%0d", u, budget,
                     (u == 0) ? q1.size() : q2.size());
            if (u == 0) q1.delete(); else q2.delete();
        end
        tick();
    endtask

    task automatic check_done(input int u);
        exp_t        e;
        logic [15:0] c;
        longint      s;
        logic [7:0]  en;
        if (u == 0) begin c = ctrl1; s = stat1; en = en1; end
        else        begin c = ctrl2; s = longint'(stat2); en = en2; end
        if (((u == 0) ? q1.size() : q2.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done_u%0d: dataready rose with nothing pending, status=%0d", u, s);
            return;
        end
        if (u == 0) e = q1.pop_front(); else e = q2.pop_front();
        chk($sformatf("done_cycle_u%0d", u), cyc, e.cyc, e.cyc);
        chk($sformatf("status_u%0d", u), s, e.lo, e.hi);
        chk($sformatf("aborted_u%0d", u), c[11], e.aborted, e.aborted);
        chk($sformatf("sat_u%0d", u), c[13], e.sat, e.sat);
        chk($sformatf("run_off_u%0d", u), c[10], 0, 0);
        chk($sformatf("en_off_u%0d", u), en, 0, 0);
    endtask

    initial begin : mon1
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge pclk);
            if (!presetn) prev = 1'b1;
            else begin
                if (!prev && dr1) check_done(0);
                prev = dr1;
            end
        end
    end

    initial begin : mon2
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge pclk);
            if (!presetn) prev = 1'b1;
            else begin
                if (!prev && dr2) check_done(1);
                prev = dr2;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        #2;
        chk("rst_dataready", dr1, 1, 1);
        chk("rst_ctrl", ctrl1, 0, 0);
        chk("rst_ref", ref1, 0, 0);
        chk("rst_status", stat1, 0, 0);
        chk("rst_en", en1, 0, 0);
        #20 presetn = 1'b1;
        tick(); tick();

        // Out-of-range select: flag only, no measurement.
        ctrl_wr(0, 16'h0109);
        chk("sel_err_ctrl", ctrl1, 16'h1009, 16'h1009);
        chk("sel_err_dataready", dr1, 1, 1);
        stat_read(0);
        chk("sel_err_cleared", ctrl1, 16'h0009, 16'h0009);

        // Nominal window of 100 on sensor 2.
        ref_wr(0, 32'd100);
        chk("ref_readback", ref1, 100, 100);
        t0 = cyc;
        expect_done(0, t0 + 104, 9, 11, 1'b0, 1'b0);
        ctrl_wr(0, 16'h0102);
        chk("arm_run", ctrl1[10], 1, 1);
        chk("arm_dataready", dr1, 0, 0);
        chk("arm_sensor_en", en1, 8'h04, 8'h04);
        wait_drained(0, 200);

        // Zero window on a silent sensor.
        ref_wr(0, 32'd0);
        t0 = cyc;
        expect_done(0, t0 + 4, 0, 0, 1'b0, 1'b0);
        ctrl_wr(0, 16'h0105);
        wait_drained(0, 50);

        // Abort mid-count.
        ref_wr(0, 32'd1000);
        t0 = cyc;
        expect_done(0, t0 + 51, 3, 6, 1'b1, 1'b0);
        ctrl_wr(0, 16'h0102);
        while (cyc < t0 + 50) tick();
        ctrl_wr(0, 16'h0200);
        wait_drained(0, 20);
        stat_read(0);
        chk("aborted_cleared", ctrl1[11], 0, 0);

        // START with ABORT: abort wins, and abort in IDLE is a no-op.
        ctrl_wr(0, 16'h0302);
        chk("start_abort_dataready", dr1, 1, 1);
        chk("start_abort_run", ctrl1[10], 0, 0);
        chk("start_abort_no_flag", ctrl1[11], 0, 0);
        tick();
        chk("start_abort_still_idle", dr1, 1, 1);

        // Saturation on the 4-bit instance.
        ref_wr(1, 32'd200);
        t0 = cyc;
        expect_done(1, t0 + 204, 15, 15, 1'b0, 1'b1);
        ctrl_wr(1, 16'h0100);
        wait_drained(1, 300);

        // Asynchronous reset in the middle of a count.
        ref_wr(0, 32'd1000);
        ctrl_wr(0, 16'h0102);
        repeat (20) tick();
        chk("mid_count_busy", dr1, 0, 0);
        #2 presetn = 1'b0;
        #1;
        chk("arst_dataready", dr1, 1, 1);
        chk("arst_ctrl", ctrl1, 0, 0);
        chk("arst_status", stat1, 0, 0);
        chk("arst_en", en1, 0, 0);
        chk("arst_ref", ref1, 0, 0);
        chk("arst_status_sat_inst", stat2, 0, 0);
        @(negedge pclk);
        chk("arst_next_dataready", dr1, 1, 1);
        chk("arst_next_ctrl", ctrl1, 0, 0);
        #3 presetn = 1'b1;
        tick(); tick();
        chk("post_rst_idle", dr1, 1, 1);

        chk("scoreboard_empty_u0", q1.size(), 0, 0);
        chk("scoreboard_empty_u1", q2.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
